// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the PSRAM arbiter between the DCJ11 CPU
// port and the Apple II host port.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the CPU, HOST and PSRAM-controller handshakes seen by ram_arbiter.
// slave is the arbiter's view; master is the view of the surrounding logic.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_byte;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_err;

    logic              host_req;
    logic              host_we;
    logic              host_byte;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_done;
    logic              host_err;

    logic              ram_read;
    logic              ram_write;
    logic              ram_byte;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_done;
    logic              ram_busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_err,
        input  host_req, host_we, host_byte, host_addr, host_wdata,
        output host_rdata, host_done, host_err,
        output ram_read, ram_write, ram_byte, ram_addr, ram_wdata,
        input  ram_rdata, ram_done, ram_busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_err,
        output host_req, host_we, host_byte, host_addr, host_wdata,
        input  host_rdata, host_done, host_err,
        input  ram_read, ram_write, ram_byte, ram_addr, ram_wdata,
        output ram_rdata, ram_done, ram_busy
    );

endinterface

// File: rtl/ram_arbiter.sv
// Serialises CPU and HOST transactions onto the single PSRAM controller.
// CPU has fixed priority; an aging counter forces a starved host to win.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int HOST_MAX_WAIT = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);

    localparam int AGE_W = $clog2(HOST_MAX_WAIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(HOST_MAX_WAIT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_t            state_reg;
    owner_t            owner_reg;
    logic              we_reg;
    logic [AGE_W-1:0]  host_age_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [TMO_W-1:0]  tmo_cnt_next;

    logic              arb_go;
    logic              age_full;
    logic              host_wins;
    logic              tmo_hit;
    logic              win_we;
    logic              win_byte;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Arbitration only happens from IDLE, so the port that just finished in
    // DONE can never be re-granted before it has had a cycle to drop req.
    assign arb_go    = (state_reg == IDLE) && (bus.cpu_req || bus.host_req) && !bus.ram_busy;
    assign age_full  = (host_age_reg >= AGE_MAX);
    assign host_wins = bus.host_req && (!bus.cpu_req || age_full);

    assign win_we    = host_wins ? bus.host_we    : bus.cpu_we;
    assign win_byte  = host_wins ? bus.host_byte  : bus.cpu_byte;
    assign win_addr  = host_wins ? bus.host_addr  : bus.cpu_addr;
    assign win_wdata = host_wins ? bus.host_wdata : bus.cpu_wdata;

    assign tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    assign tmo_hit      = (tmo_cnt_next == TMO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_age_reg <= '0;
        end else if (!bus.host_req) begin
            host_age_reg <= '0;
        end else if (arb_go) begin
            if (host_wins)
                host_age_reg <= '0;
            else if (!age_full)
                host_age_reg <= host_age_reg + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_CPU;
            we_reg         <= 1'b0;
            tmo_cnt_reg    <= '0;
            bus.ram_read   <= 1'b0;
            bus.ram_write  <= 1'b0;
            bus.ram_byte   <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.cpu_rdata  <= '0;
            bus.cpu_done   <= 1'b0;
            bus.cpu_err    <= 1'b0;
            bus.host_rdata <= '0;
            bus.host_done  <= 1'b0;
            bus.host_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_go) begin
                        owner_reg     <= host_wins ? OWN_HOST : OWN_CPU;
                        we_reg        <= win_we;
                        bus.ram_addr  <= win_addr;
                        bus.ram_wdata <= win_wdata;
                        // Command is registered here so it is visible for exactly the ISSUE cycle.
                        bus.ram_read  <= !win_we;
                        bus.ram_write <= win_we;
                        bus.ram_byte  <= win_we & win_byte;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ram_read  <= 1'b0;
                    bus.ram_write <= 1'b0;
                    bus.ram_byte  <= 1'b0;
                    tmo_cnt_reg   <= '0;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (bus.ram_done || tmo_hit) begin
                        state_reg <= DONE;
                        if (owner_reg == OWN_CPU) begin
                            bus.cpu_done <= 1'b1;
                            bus.cpu_err  <= !bus.ram_done;
                            if (bus.ram_done && !we_reg)
                                bus.cpu_rdata <= bus.ram_rdata;
                        end else begin
                            bus.host_done <= 1'b1;
                            bus.host_err  <= !bus.ram_done;
                            if (bus.ram_done && !we_reg)
                                bus.host_rdata <= bus.ram_rdata;
                        end
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_next;
                    end
                end
                DONE: begin
                    bus.cpu_done  <= 1'b0;
                    bus.cpu_err   <= 1'b0;
                    bus.host_done <= 1'b0;
                    bus.host_err  <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter; the bench plays both requesters
// and the PSRAM controller.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cpu_done_cnt  = 0;
    int   host_done_cnt = 0;
    int   c0, h0, n;

    ram_arbiter_if #(.ADDR_W(22), .DATA_W(16)) bus();

    ram_arbiter #(
        .ADDR_W(22), .DATA_W(16), .HOST_MAX_WAIT(8), .TIMEOUT(255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.cpu_done)  cpu_done_cnt  <= cpu_done_cnt + 1;
        if (bus.host_done) host_done_cnt <= host_done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Steps negedges until a command is on the bus, bounded.
    task automatic wait_cmd(input string tag);
        int k = 0;
        while (!(bus.ram_read || bus.ram_write) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " cmd_seen"}, 32'(k < 50), 32'd1);
    endtask

    // One read transaction: command, one WAIT cycle, then ram_done.
    task automatic serve(input string tag, input bit exp_host, input logic [15:0] rd);
        wait_cmd(tag);
        chk({tag, " addr"}, 32'(bus.ram_addr), exp_host ? 32'(bus.host_addr) : 32'(bus.cpu_addr));
        @(negedge clk);
        bus.ram_rdata = rd;
        bus.ram_done  = 1'b1;
        @(negedge clk);
        bus.ram_done  = 1'b0;
        chk({tag, " cpu_done"},  32'(bus.cpu_done),  32'(!exp_host));
        chk({tag, " host_done"}, 32'(bus.host_done), 32'(exp_host));
        chk({tag, " rdata"}, exp_host ? 32'(bus.host_rdata) : 32'(bus.cpu_rdata), 32'(rd));
    endtask

    initial begin
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_byte = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_byte = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.ram_rdata = '0; bus.ram_done = 0; bus.ram_busy = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst ram_read",  32'(bus.ram_read),  0);
        chk("rst ram_write", 32'(bus.ram_write), 0);
        chk("rst cpu_done",  32'(bus.cpu_done),  0);
        chk("rst host_done", 32'(bus.host_done), 0);
        chk("rst ram_addr",  32'(bus.ram_addr),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU read, ram_done 4 cycles after ram_read
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 22'o001000;
        @(negedge clk);
        chk("rd ram_read",  32'(bus.ram_read),  1);
        chk("rd ram_write", 32'(bus.ram_write), 0);
        chk("rd ram_addr",  32'(bus.ram_addr),  32'o001000);
        @(negedge clk);
        chk("rd ram_read pulse", 32'(bus.ram_read), 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rd early done", 32'(bus.cpu_done), 0);
        bus.ram_rdata = 16'o123456; bus.ram_done = 1;
        @(negedge clk);
        bus.ram_done = 0;
        chk("rd cpu_done",  32'(bus.cpu_done),  1);
        chk("rd cpu_rdata", 32'(bus.cpu_rdata), 32'o123456);
        chk("rd cpu_err",   32'(bus.cpu_err),   0);
        chk("rd host_done", 32'(bus.host_done), 0);
        bus.cpu_req = 0;
        @(negedge clk);
        chk("rd done pulse", 32'(bus.cpu_done), 0);

        // CPU byte write
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_byte = 1;
        bus.cpu_addr = 22'o001001; bus.cpu_wdata = 16'h00A5;
        @(negedge clk);
        chk("bw ram_write", 32'(bus.ram_write), 1);
        chk("bw ram_byte",  32'(bus.ram_byte),  1);
        chk("bw ram_read",  32'(bus.ram_read),  0);
        chk("bw ram_addr",  32'(bus.ram_addr),  32'o001001);
        chk("bw ram_wdata", 32'(bus.ram_wdata), 32'h00A5);
        @(negedge clk);
        chk("bw ram_write pulse", 32'(bus.ram_write), 0);
        chk("bw ram_byte pulse",  32'(bus.ram_byte),  0);
        bus.ram_rdata = 16'hDEAD; bus.ram_done = 1;
        @(negedge clk);
        bus.ram_done = 0;
        chk("bw cpu_done",  32'(bus.cpu_done),  1);
        chk("bw rdata kept", 32'(bus.cpu_rdata), 32'o123456);
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_byte = 0;
        @(negedge clk);

        // Busy controller blocks issue
        bus.ram_busy = 1; bus.cpu_req = 1; bus.cpu_addr = 22'o001000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy no cmd", 32'(bus.ram_read), 0);
        end
        bus.ram_busy = 0;
        serve("busy release", 0, 16'h1234);
        bus.cpu_req = 0;
        @(negedge clk);

        // Host aging: CPU held, host pending -> 8 CPU wins then host
        bus.host_addr = 22'o003000; bus.host_we = 0;
        bus.cpu_req = 1; bus.host_req = 1;
        for (int i = 0; i < 8; i++) serve("age cpu", 0, 16'(16'h1000 + i));
        serve("age host", 1, 16'hBEEF);
        bus.host_req = 0;
        @(negedge clk);
        chk("age cleared", 32'(dut.host_age_reg), 0);
        serve("age post cpu", 0, 16'h2222);
        bus.cpu_req = 0;
        @(negedge clk);
        @(negedge clk);

        // Simultaneous requests with age 0
        c0 = cpu_done_cnt; h0 = host_done_cnt;
        bus.host_addr = 22'o003002;
        bus.cpu_req = 1; bus.host_req = 1;
        serve("sim cpu", 0, 16'h3333);
        bus.cpu_req = 0;
        serve("sim host", 1, 16'h4444);
        bus.host_req = 0;
        repeat (3) @(negedge clk);
        chk("sim cpu one done",  32'(cpu_done_cnt - c0),  1);
        chk("sim host one done", 32'(host_done_cnt - h0), 1);

        // Timeout: no ram_done
        bus.cpu_req = 1; bus.cpu_addr = 22'o002000;
        wait_cmd("tmo");
        n = 0;
        while (!bus.cpu_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tmo latency", 32'(n), 32'd256);
        chk("tmo cpu_err", 32'(bus.cpu_err), 1);
        bus.cpu_req = 0;
        @(negedge clk);
        chk("tmo err pulse", 32'(bus.cpu_err), 0);

        // ram_done on the timeout cycle wins
        bus.cpu_req = 1;
        wait_cmd("tie");
        repeat (255) @(negedge clk);
        chk("tie early done", 32'(bus.cpu_done), 0);
        bus.ram_rdata = 16'h5A5A; bus.ram_done = 1;
        @(negedge clk);
        bus.ram_done = 0;
        chk("tie cpu_done",  32'(bus.cpu_done),  1);
        chk("tie cpu_err",   32'(bus.cpu_err),   0);
        chk("tie cpu_rdata", 32'(bus.cpu_rdata), 32'h5A5A);
        bus.cpu_req = 0;
        @(negedge clk);

        bus.cpu_req = 1;
        serve("after tmo", 0, 16'h6666);
        chk("after tmo err", 32'(bus.cpu_err), 0);
        bus.cpu_req = 0;
        @(negedge clk);

        // Reset during WAIT
        bus.cpu_req = 1; bus.cpu_addr = 22'o004000;
        wait_cmd("rstw");
        @(negedge clk);
        @(negedge clk);
        c0 = cpu_done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rstw ram_addr",  32'(bus.ram_addr),  0);
        chk("rstw cpu_rdata", 32'(bus.cpu_rdata), 0);
        chk("rstw ram_read",  32'(bus.ram_read),  0);
        chk("rstw state",     32'(dut.state_reg), 32'(IDLE));
        bus.cpu_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstw no done", 32'(cpu_done_cnt - c0), 0);
        bus.cpu_req = 1;
        serve("rstw fresh", 0, 16'h7777);
        bus.cpu_req = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
